// File: rtl/copro_issue_ctrl.sv
// copro_issue_ctrl
//   Issue controller for the GCD/LCM/MOD coprocessor. It picks coprocessor
//   opcodes out of decode, latches operands and destination, runs a
//   start/done handshake with the coprocessor, stalls the core meanwhile,
//   resolves zero-operand cases locally, aborts on timeout and honours flush.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   issue_valid_i             decode-stage instruction valid
//   op_i, funct3_i, rd_i      opcode, funct3 and destination register
//   rs1_val_i, rs2_val_i      register-file operands
//   flush_i                   kill the in-flight operation
//   stall_o                   hold PC/decode (combinational)
//   ill_o                     unsupported funct3 on a coprocessor opcode (combinational)
//   cp_start_o, cp_abort_o    one-cycle start / abort pulses to the coprocessor
//   cp_mode_o                 00 gcd, 01 lcm, 10 mod
//   cp_a_o, cp_b_o            latched operands
//   cp_done_i, cp_result_i    coprocessor result handshake
//   wb_valid_o, wb_rd_o,
//   wb_data_o                 register-file write-back
//   err_o                     one-cycle timeout pulse
module copro_issue_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            issue_valid_i,
  input  logic [6:0]      op_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            ill_o,
  output logic            cp_start_o,
  output logic            cp_abort_o,
  output logic [1:0]      cp_mode_o,
  output logic [XLEN-1:0] cp_a_o,
  output logic [XLEN-1:0] cp_b_o,
  input  logic            cp_done_i,
  input  logic [XLEN-1:0] cp_result_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o
);

  // A zero timeout leaves CNT_W at 0; keep the counter at least one bit wide.
  localparam int unsigned    CW     = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT_CYC);
  localparam logic           TO_EN  = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WB
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [4:0]      rd_q, rd_d;
  logic            start_q, start_d;
  logic            abort_q, abort_d;
  logic            err_q, err_d;
  logic            wbv_q, wbv_d;
  logic [XLEN-1:0] wbd_q, wbd_d;

  logic            is_cp_op;
  logic            legal_op;
  logic            accept;
  logic            sc_hit;
  logic [XLEN-1:0] sc_val;
  logic            timeout_hit;

  assign is_cp_op = (op_i == 7'b0000000) || (op_i == 7'b0000001) || (op_i == 7'b0000010);
  assign legal_op = is_cp_op && (funct3_i == 3'b000);

  // reset_n is folded in so the combinational outputs also read 0 in reset.
  assign accept = reset_n && (state_q == S_IDLE) && issue_valid_i && legal_op && !flush_i;
  assign ill_o  = reset_n && (state_q == S_IDLE) && issue_valid_i && is_cp_op &&
                  (funct3_i != 3'b000) && !flush_i;
  assign stall_o = accept || (state_q == S_START) || (state_q == S_WAIT);

  assign timeout_hit = TO_EN && (cnt_q == TO_VAL);

  // Zero-operand results resolved without the coprocessor.
  always_comb begin
    sc_hit = 1'b0;
    sc_val = '0;
    unique case (op_i[1:0])
      2'b00: begin
        if (rs1_val_i == '0) begin
          sc_hit = 1'b1;
          sc_val = rs2_val_i;
        end else if (rs2_val_i == '0) begin
          sc_hit = 1'b1;
          sc_val = rs1_val_i;
        end
      end
      2'b01: begin
        if ((rs1_val_i == '0) || (rs2_val_i == '0)) begin
          sc_hit = 1'b1;
          sc_val = '0;
        end
      end
      2'b10: begin
        if (rs2_val_i == '0) begin
          sc_hit = 1'b1;
          sc_val = rs1_val_i;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    err_d   = 1'b0;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d = op_i[1:0];
          a_d    = rs1_val_i;
          b_d    = rs2_val_i;
          rd_d   = rd_i;
          if (sc_hit) begin
            state_d = S_WB;
            wbd_d   = sc_val;
            wbv_d   = (rd_i != '0);
          end else begin
            state_d = S_START;
            start_d = 1'b1;
          end
        end
      end
      S_START: begin
        cnt_d = '0;
        if (flush_i) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (cp_done_i) begin
          state_d = S_WB;
          wbd_d   = cp_result_i;
          wbv_d   = (rd_q != '0);
        end else if (timeout_hit) begin
          state_d = S_WB;
          wbd_d   = '1;
          wbv_d   = (rd_q != '0);
          err_d   = 1'b1;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      wbv_q   <= 1'b0;
      wbd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      start_q <= start_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
    end
  end

  assign cp_start_o = start_q;
  assign cp_abort_o = abort_q;
  assign cp_mode_o  = mode_q;
  assign cp_a_o     = a_q;
  assign cp_b_o     = b_q;
  assign err_o      = err_q;
  assign wb_rd_o    = rd_q;
  assign wb_data_o  = wbd_q;
  // The enable is only known to be stale once the WB cycle itself sees a
  // flush, so the registered enable is qualified by flush_i on the way out.
  assign wb_valid_o = wbv_q && !flush_i;

endmodule

// File: tb/tb_copro_issue_ctrl.sv
module tb_copro_issue_ctrl;

  localparam int TO = 8;
  localparam int CH_START = 0, CH_WB = 1, CH_ERR = 2, CH_ABORT = 3, CH_ILL = 4;

  logic        clk;
  logic        reset_n;
  logic        issue_valid_i;
  logic [6:0]  op_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic [31:0] rs1_val_i, rs2_val_i;
  logic        flush_i;
  logic        stall_o, ill_o, cp_start_o, cp_abort_o;
  logic [1:0]  cp_mode_o;
  logic [31:0] cp_a_o, cp_b_o;
  logic        cp_done_i;
  logic [31:0] cp_result_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  copro_issue_ctrl #(.XLEN(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .issue_valid_i(issue_valid_i), .op_i(op_i),
    .funct3_i(funct3_i), .rd_i(rd_i), .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i),
    .flush_i(flush_i), .stall_o(stall_o), .ill_o(ill_o), .cp_start_o(cp_start_o),
    .cp_abort_o(cp_abort_o), .cp_mode_o(cp_mode_o), .cp_a_o(cp_a_o), .cp_b_o(cp_b_o),
    .cp_done_i(cp_done_i), .cp_result_i(cp_result_i), .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } ev_t;

  ev_t qs[5][$];
  bit  exp_stall[int];
  int  dq[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic [31:0] ref_op(input int mode, input logic [31:0] a, input logic [31:0] b);
    case (mode)
      0: return ref_gcd(a, b);
      1: return (a == 0 || b == 0) ? 32'd0 : (a / ref_gcd(a, b)) * b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_shortcut(input int mode, input logic [31:0] a, input logic [31:0] b);
    if (mode == 2) return (b == 0);
    return (a == 0 || b == 0);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int ch, input int c, input logic [127:0] d);
    ev_t e;
    e.cyc  = c;
    e.data = d;
    qs[ch].push_back(e);
  endtask

  task automatic mon_chan(input int ch, input string name, input logic sig,
                          input bit has_data, input logic [127:0] act);
    bit  exp_now;
    ev_t e;
    exp_now = (qs[ch].size() > 0) && (qs[ch][0].cyc == cyc);
    check(name, 128'(sig), 128'(exp_now));
    if (exp_now) begin
      e = qs[ch].pop_front();
      if (has_data && sig) check({name, "_data"}, act, e.data);
    end
  endtask

  // Monitor: compares every output event against the scoreboard queues.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      mon_chan(CH_START, "start", cp_start_o, 1, 128'({cp_mode_o, cp_a_o, cp_b_o}));
      mon_chan(CH_WB, "wb", wb_valid_o, 1, 128'({wb_rd_o, wb_data_o}));
      mon_chan(CH_ERR, "err", err_o, 0, '0);
      mon_chan(CH_ABORT, "abort", cp_abort_o, 0, '0);
      mon_chan(CH_ILL, "ill", ill_o, 0, '0);
      check("stall", 128'(stall_o), 128'(exp_stall.exists(cyc) ? 1 : 0));
    end
  end

  // Coprocessor responder: done after the delay the driver queued (0 = never).
  initial begin
    int          remain;
    bit          pending;
    int          d;
    logic [31:0] res;
    cp_done_i   = 0;
    cp_result_i = 0;
    pending     = 0;
    remain      = 0;
    res         = 0;
    forever begin
      @(posedge clk);
      #1;
      cp_done_i   = 0;
      cp_result_i = $urandom;
      if (!reset_n) pending = 0;
      else begin
        if (cp_abort_o) pending = 0;
        if (pending) begin
          remain--;
          if (remain == 0) begin
            cp_done_i   = 1;
            cp_result_i = res;
            pending     = 0;
          end
        end
        if (cp_start_o) begin
          d   = (dq.size() > 0) ? dq.pop_front() : 0;
          res = ref_op(int'(cp_mode_o), cp_a_o, cp_b_o);
          if (d > 0) begin
            pending = 1;
            remain  = d;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk();
    issue_valid_i = 1'($urandom_range(0, 1));
    op_i          = 7'($urandom_range(0, 3));
    funct3_i      = 3'($urandom);
    rd_i          = 5'($urandom);
    rs1_val_i     = $urandom;
    rs2_val_i     = $urandom;
    flush_i       = 0;
  endtask

  task automatic drive_quiet();
    drive_junk();
    issue_valid_i = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 128'(stall_o), '0);
    check({tag, "_ill"}, 128'(ill_o), '0);
    check({tag, "_start"}, 128'(cp_start_o), '0);
    check({tag, "_abort"}, 128'(cp_abort_o), '0);
    check({tag, "_mode"}, 128'(cp_mode_o), '0);
    check({tag, "_a"}, 128'(cp_a_o), '0);
    check({tag, "_b"}, 128'(cp_b_o), '0);
    check({tag, "_wbv"}, 128'(wb_valid_o), '0);
    check({tag, "_wbrd"}, 128'(wb_rd_o), '0);
    check({tag, "_wbd"}, 128'(wb_data_o), '0);
    check({tag, "_err"}, 128'(err_o), '0);
  endtask

  // fl: 0 none, 1 flush in START, 2 flush in WAIT on the done cycle, 3 flush in WB.
  // d: done delay after the start pulse, 0 = never (timeout).
  task automatic do_op(input int mode, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int d, input int fl);
    int          t, w, dc, idle, fcyc;
    bit          sc;
    logic [31:0] res;
    t    = cyc;
    sc   = is_shortcut(mode, a, b);
    res  = ref_op(mode, a, b);
    fcyc = -1;
    issue_valid_i = 1;
    op_i          = 7'(mode);
    funct3_i      = 0;
    rd_i          = rd;
    rs1_val_i     = a;
    rs2_val_i     = b;
    flush_i       = 0;
    exp_stall[t]  = 1;
    dc = t + 1 + d;
    if (sc) w = t + 1;
    else begin
      push(CH_START, t + 1, 128'({2'(mode), a, b}));
      dq.push_back(d);
      w = (d > 0) ? dc + 1 : t + 3 + TO;
    end
    if (!sc && fl == 1) begin
      fcyc = t + 1;
      exp_stall[t + 1] = 1;
      push(CH_ABORT, t + 2, '0);
      idle = t + 2;
    end else if (!sc && fl == 2 && d > 0) begin
      fcyc = dc;
      for (int c = t + 1; c <= dc; c++) exp_stall[c] = 1;
      push(CH_ABORT, dc + 1, '0);
      idle = dc + 1;
    end else begin
      for (int c = t + 1; c < w; c++) exp_stall[c] = 1;
      if (!sc && d == 0) begin
        push(CH_ERR, w, '0);
        push(CH_ABORT, w, '0);
        res = '1;
      end
      if (fl == 3) fcyc = w;
      else if (rd != 0) push(CH_WB, w, 128'({rd, res}));
      idle = w + 1;
    end
    while (cyc < idle) begin
      tick();
      if (cyc < idle) drive_junk();
      else drive_quiet();
      flush_i = (cyc == fcyc);
    end
  endtask

  task automatic do_ill(input int mode, input logic [2:0] f3);
    issue_valid_i = 1;
    op_i          = 7'(mode);
    funct3_i      = f3;
    rd_i          = 5'($urandom);
    rs1_val_i     = $urandom;
    rs2_val_i     = $urandom;
    flush_i       = 0;
    push(CH_ILL, cyc, '0);
    tick();
    drive_quiet();
  endtask

  task automatic do_idle_flush();
    issue_valid_i = 1;
    op_i          = 7'($urandom_range(0, 2));
    funct3_i      = 0;
    rd_i          = 5'($urandom_range(1, 31));
    rs1_val_i     = $urandom_range(1, 100);
    rs2_val_i     = $urandom_range(1, 100);
    flush_i       = 1;
    tick();
    drive_quiet();
  endtask

  task automatic gap(input int n);
    logic [6:0] nonc [4];
    nonc[0] = 7'h03; nonc[1] = 7'h13; nonc[2] = 7'h33; nonc[3] = 7'h7f;
    for (int i = 0; i < n; i++) begin
      drive_quiet();
      issue_valid_i = 1'($urandom_range(0, 1));
      op_i          = nonc[$urandom_range(0, 3)];
      tick();
    end
    drive_quiet();
  endtask

  function automatic logic [31:0] rnd_operand();
    return ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 500));
  endfunction

  initial begin
    int t;
    reset_n = 0;
    drive_quiet();
    repeat (3) tick();
    check_zero("reset");
    reset_n = 1;
    mon_en  = 1;
    tick();

    do_op(0, 48, 18, 5, 3, 0);
    do_op(1, 0, 7, 3, 1, 0);
    do_op(0, 0, 9, 11, 1, 0);
    do_op(2, 10, 0, 12, 1, 0);
    do_op(0, 14, 0, 10, 1, 0);
    gap(1);
    do_op(2, 100, 7, 0, 2, 0);
    do_op(0, 12, 8, 7, 0, 0);
    do_op(0, 20, 15, 4, 2, 2);
    do_ill(1, 3'b011);
    do_op(0, 36, 24, 1, 1, 0);
    do_op(1, 4, 6, 2, 1, 0);
    do_op(2, 50, 9, 6, 4, 1);
    do_op(1, 6, 10, 8, 2, 3);
    do_idle_flush();
    gap(2);

    for (int i = 0; i < 40; i++) begin
      int r, fl, d;
      r  = $urandom_range(0, 9);
      fl = (r < 3) ? r + 1 : 0;
      d  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      do_op($urandom_range(0, 2), rnd_operand(), rnd_operand(), 5'($urandom), d, fl);
      case ($urandom_range(0, 5))
        0: do_ill($urandom_range(0, 2), 3'($urandom_range(1, 7)));
        1: do_idle_flush();
        2: gap($urandom_range(1, 2));
        default: ;
      endcase
    end

    // Reset in the middle of WAIT.
    t = cyc;
    issue_valid_i = 1;
    op_i          = 7'd0;
    funct3_i      = 0;
    rd_i          = 5'd9;
    rs1_val_i     = 30;
    rs2_val_i     = 12;
    flush_i       = 0;
    push(CH_START, t + 1, 128'({2'd0, 32'd30, 32'd12}));
    dq.push_back(0);
    for (int c = t; c <= t + 3; c++) exp_stall[c] = 1;
    repeat (3) begin
      tick();
      drive_junk();
    end
    #1;
    mon_en  = 0;
    reset_n = 0;
    #1;
    check_zero("async_rst");
    tick();
    check_zero("rst_hold");
    reset_n = 1;
    drive_quiet();
    mon_en = 1;
    tick();

    do_op(1, 21, 6, 13, 2, 0);
    gap(3);

    for (int ch = 0; ch < 5; ch++) check("queue_empty", 128'(qs[ch].size()), '0);
    check("delay_queue_empty", 128'(dq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
